// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and HI/LO multiply-divide helpers.
// Used by both the instruction decoder and muldiv_unit.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  function automatic logic md_is_signed(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic [31:0] abs32(logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Pipeline <-> multiply/divide unit connection: request inputs and HI/LO/status outputs.
interface muldiv_unit_if;
  import mips_pkg::*;

  logic        start;
  md_op_t      md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        write_hi;
  logic        write_lo;
  logic        rd_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, md_op, rs_data, rt_data, write_hi, write_lo, rd_req,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, md_op, rs_data, rt_data, write_hi, write_lo, rd_req,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
// Multiply: {upper,lower} is the partial product; divide: upper=remainder, lower=dividend/quotient.
module muldiv_step (
  input  logic        is_div,
  input  logic [31:0] upper_in,
  input  logic [31:0] lower_in,
  input  logic [31:0] operand,
  output logic [31:0] upper_out,
  output logic [31:0] lower_out
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;

  always_comb begin
    sum     = lower_in[0] ? ({1'b0, upper_in} + {1'b0, operand}) : {1'b0, upper_in};
    shifted = {upper_in, lower_in[31]};
    fits    = (shifted >= {1'b0, operand});
    // Both the difference and the un-subtracted value are below the divisor, so 32 bits suffice.
    diff    = shifted[31:0] - operand;

    if (is_div) begin
      upper_out = fits ? diff : shifted[31:0];
      lower_out = {lower_in[30:0], fits};
    end else begin
      upper_out = sum[32:1];
      lower_out = {sum[0], lower_in[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32 iterations, a drain cycle and a sign-fix cycle.
// Owns the architectural HI/LO registers and the pipeline stall request.
module muldiv_unit
  import mips_pkg::*;
(
  input logic            clk,
  input logic            rst,
  muldiv_unit_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  count;
  md_op_t      op;
  logic [31:0] upper;
  logic [31:0] lower;
  logic [31:0] operand;
  logic [31:0] dividend;
  logic        neg_result;
  logic        neg_rem;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  logic [31:0] step_upper;
  logic [31:0] step_lower;
  logic [63:0] product;
  logic [63:0] product_fixed;
  logic [31:0] quotient_fixed;
  logic [31:0] remainder_fixed;
  logic        busy;

  muldiv_step u_step (
    .is_div    (md_is_div(op)),
    .upper_in  (upper),
    .lower_in  (lower),
    .operand   (operand),
    .upper_out (step_upper),
    .lower_out (step_lower)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (count == 6'd32) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    product         = {upper, lower};
    product_fixed   = neg_result ? (~product + 64'd1) : product;
    quotient_fixed  = neg_result ? (~lower + 32'd1) : lower;
    remainder_fixed = neg_rem ? (~upper + 32'd1) : upper;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= 6'd0;
      op         <= MD_MULT;
      upper      <= 32'd0;
      lower      <= 32'd0;
      operand    <= 32'd0;
      dividend   <= 32'd0;
      neg_result <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero   <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      done       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == FIX);
      case (state)
        IDLE: begin
          if (bus.start) begin
            // A start wins over a same-cycle mthi/mtlo; the result overwrites HI/LO anyway.
            op         <= bus.md_op;
            count      <= 6'd0;
            upper      <= 32'd0;
            lower      <= md_is_signed(bus.md_op) ? abs32(bus.rs_data) : bus.rs_data;
            operand    <= md_is_signed(bus.md_op) ? abs32(bus.rt_data) : bus.rt_data;
            dividend   <= bus.rs_data;
            neg_result <= md_is_signed(bus.md_op) & (bus.rs_data[31] ^ bus.rt_data[31]);
            neg_rem    <= md_is_signed(bus.md_op) & bus.rs_data[31];
            div_zero   <= md_is_div(bus.md_op) & (bus.rt_data == 32'd0);
          end else begin
            if (bus.write_hi) hi <= bus.rs_data;
            if (bus.write_lo) lo <= bus.rs_data;
          end
        end
        CALC: begin
          if (count != 6'd32) begin
            upper <= step_upper;
            lower <= step_lower;
            count <= count + 6'd1;
          end
        end
        FIX: begin
          if (div_zero) begin
            lo <= 32'hFFFF_FFFF;
            hi <= dividend;
          end else if (md_is_div(op)) begin
            lo <= quotient_fixed;
            hi <= remainder_fixed;
          end else begin
            hi <= product_fixed[63:32];
            lo <= product_fixed[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.hi    = hi;
  assign bus.lo    = lo;
  assign bus.stall = busy & (bus.start | bus.rd_req | bus.write_hi | bus.write_lo);

endmodule
